// File: rtl/draw_pkg.sv
// Shared drawing-pipeline definitions: engine state encoding, VGA coordinate
// widths and default visible screen size.
package draw_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int VGA_XW = 8;
   localparam int VGA_YW = 7;
   localparam int VGA_CW = 3;

   localparam int DEF_SCREEN_W = 160;
   localparam int DEF_SCREEN_H = 120;

endpackage

// File: rtl/rect_scanner.sv
// Row-major offset counters for the rectangle fill: dx runs fastest, dy steps
// when dx wraps, and last flags the final position of the rectangle.
module rect_scanner #(
   parameter int XW = 8,
   parameter int YW = 7
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          i_clear,
   input  logic          i_advance,
   input  logic [XW-1:0] i_w,
   input  logic [YW-1:0] i_h,
   output logic [XW-1:0] o_dx,
   output logic [YW-1:0] o_dy,
   output logic          o_last
);

   logic [XW-1:0] r_dx;
   logic [YW-1:0] r_dy;
   logic          w_row_end;

   // Compare before incrementing so a full-width extent never needs a carry bit.
   assign w_row_end = (r_dx == i_w);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_dx <= '0;
         r_dy <= '0;
      end else if (i_clear) begin
         r_dx <= '0;
         r_dy <= '0;
      end else if (i_advance) begin
         if (!w_row_end) begin
            r_dx <= r_dx + 1'b1;
         end else begin
            r_dx <= '0;
            if (r_dy != i_h) begin
               r_dy <= r_dy + 1'b1;
            end
         end
      end
   end

   assign o_dx   = r_dx;
   assign o_dy   = r_dy;
   assign o_last = w_row_end & (r_dy == i_h);

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle raster-fill engine feeding the framebuffer write port.
// Optional screen clipping is enabled by defining RECT_FILL_CLIP_EN.
module rect_fill_engine
   import draw_pkg::*;
#(
   parameter int XW       = VGA_XW,
   parameter int YW       = VGA_YW,
   parameter int CW       = VGA_CW,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [XW-1:0] req_x0,
   input  logic [YW-1:0] req_y0,
   input  logic [XW-1:0] req_w,
   input  logic [YW-1:0] req_h,
   input  logic [CW-1:0] req_colour,
   output logic          plot,
   input  logic          plot_ready,
   output logic [XW-1:0] plot_x,
   output logic [YW-1:0] plot_y,
   output logic [CW-1:0] plot_colour,
   output logic          busy,
   output logic          done
);

`ifdef RECT_FILL_CLIP_EN
   localparam int CXW = XW + 1;
   localparam int CYW = YW + 1;
`else
   localparam int CXW = XW;
   localparam int CYW = YW;
`endif

   state_t        r_state;
   state_t        w_state_next;

   logic [XW-1:0] r_x0;
   logic [YW-1:0] r_y0;
   logic [XW-1:0] r_w;
   logic [YW-1:0] r_h;
   logic [CW-1:0] r_colour;
   logic [XW-1:0] r_cx;
   logic [YW-1:0] r_cy;
   logic          r_plot;
   logic          r_done;
   logic          r_busy;
   logic          r_req_ready;

   logic          w_accept;
   logic          w_step;
   logic          w_row_end;
   logic          w_last;
   logic          w_in_range;
   logic [XW-1:0] w_dx;
   logic [YW-1:0] w_dy;
   logic [CXW-1:0] w_cx_cur;
   logic [CYW-1:0] w_cy_cur;
   logic [CXW-1:0] w_cx_next;
   logic [CYW-1:0] w_cy_next;

   assign w_accept  = req_valid & (r_state == S_IDLE);
   // A clipped position has no plot to wait on, so it advances unconditionally.
   assign w_step    = (r_state == S_DRAW) & (plot_ready | ~r_plot);
   assign w_row_end = (w_dx == r_w);

   rect_scanner #(
      .XW (XW),
      .YW (YW)
   ) u_scanner (
      .clock     (clock),
      .resetn    (resetn),
      .i_clear   (w_accept),
      .i_advance (w_step),
      .i_w       (r_w),
      .i_h       (r_h),
      .o_dx      (w_dx),
      .o_dy      (w_dy),
      .o_last    (w_last)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_next = S_DRAW;
         S_DRAW:  if (w_step && w_last) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Next pixel position, computed ahead so the plot outputs are pure registers.
   assign w_cx_cur = CXW'(r_x0) + CXW'(w_dx);
   assign w_cy_cur = CYW'(r_y0) + CYW'(w_dy);

   always_comb begin
      w_cx_next = w_cx_cur;
      w_cy_next = w_cy_cur;
      if (w_accept) begin
         w_cx_next = CXW'(req_x0);
         w_cy_next = CYW'(req_y0);
      end else if (w_step) begin
         if (!w_row_end) begin
            w_cx_next = w_cx_cur + 1'b1;
         end else begin
            w_cx_next = CXW'(r_x0);
            if (!w_last) begin
               w_cy_next = w_cy_cur + 1'b1;
            end
         end
      end
   end

`ifdef RECT_FILL_CLIP_EN
   localparam logic [CXW-1:0] LIM_X = CXW'(SCREEN_W);
   localparam logic [CYW-1:0] LIM_Y = CYW'(SCREEN_H);
   assign w_in_range = (w_cx_next < LIM_X) & (w_cy_next < LIM_Y);
`else
   assign w_in_range = 1'b1;
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_x0        <= '0;
         r_y0        <= '0;
         r_w         <= '0;
         r_h         <= '0;
         r_colour    <= '0;
         r_cx        <= '0;
         r_cy        <= '0;
         r_plot      <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_req_ready <= 1'b1;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_x0     <= req_x0;
            r_y0     <= req_y0;
            r_w      <= req_w;
            r_h      <= req_h;
            r_colour <= req_colour;
         end
         r_cx        <= w_cx_next[XW-1:0];
         r_cy        <= w_cy_next[YW-1:0];
         r_plot      <= (w_state_next == S_DRAW) & w_in_range;
         r_done      <= (w_state_next == S_DONE);
         r_busy      <= (w_state_next != S_IDLE);
         r_req_ready <= (w_state_next == S_IDLE);
      end
   end

   assign req_ready   = r_req_ready;
   assign plot        = r_plot;
   assign plot_x      = r_cx;
   assign plot_y      = r_cy;
   assign plot_colour = r_colour;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench for rect_fill_engine: a pixel-list reference model fills the
// expected queue per request, and a free-running monitor checks every write.
module tb_rect_fill_engine;

   localparam int XW = 8;
   localparam int YW = 7;
   localparam int CW = 3;

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [XW-1:0] req_x0 = '0;
   logic [YW-1:0] req_y0 = '0;
   logic [XW-1:0] req_w = '0;
   logic [YW-1:0] req_h = '0;
   logic [CW-1:0] req_colour = '0;
   logic          plot;
   logic          plot_ready = 1'b1;
   logic [XW-1:0] plot_x;
   logic [YW-1:0] plot_y;
   logic [CW-1:0] plot_colour;
   logic          busy;
   logic          done;

   rect_fill_engine dut (
      .clock       (clock),
      .resetn      (resetn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_x0      (req_x0),
      .req_y0      (req_y0),
      .req_w       (req_w),
      .req_h       (req_h),
      .req_colour  (req_colour),
      .plot        (plot),
      .plot_ready  (plot_ready),
      .plot_x      (plot_x),
      .plot_y      (plot_y),
      .plot_colour (plot_colour),
      .busy        (busy),
      .done        (done)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int x;
      int y;
      int c;
   } pix_t;

   pix_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   accepted = 0;
   int   done_cnt = 0;
   int   exp_done = 0;
   int   exp_plots = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: fixed pattern

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Backpressure driver.
   initial begin
      int idx;
      int last_mode;
      int pat[8];
      pat = '{1, 0, 0, 1, 1, 0, 1, 1};
      idx = 0;
      last_mode = 0;
      forever begin
         @(posedge clock);
         #1;
         if (rdy_mode != last_mode) idx = 0;
         last_mode = rdy_mode;
         case (rdy_mode)
            1:       plot_ready = ($urandom_range(0, 1) == 1);
            2:       plot_ready = (pat[idx % 8] == 1);
            default: plot_ready = 1'b1;
         endcase
         idx++;
      end
   end

   // Monitor: pops the scoreboard on every accepted write.
   initial begin
      logic held_v;
      int   hx, hy, hc;
      pix_t e;
      held_v = 1'b0;
      hx = 0; hy = 0; hc = 0;
      forever begin
         @(negedge clock);
         if (!resetn) begin
            held_v = 1'b0;
            continue;
         end
         check("ready_vs_busy", int'(req_ready), int'(!busy));
         if (held_v) begin
            check("stall_plot", int'(plot), 1);
            check("stall_x", int'(plot_x), hx);
            check("stall_y", int'(plot_y), hy);
            check("stall_colour", int'(plot_colour), hc);
         end
         if (plot && plot_ready) begin
            check("pixel_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("plot_x", int'(plot_x), e.x);
               check("plot_y", int'(plot_y), e.y);
               check("plot_colour", int'(plot_colour), e.c);
               $display("plot (%0d,%0d) c=%0d expected (%0d,%0d) c=%0d", plot_x, plot_y,
                        plot_colour, e.x, e.y, e.c);
            end
            accepted++;
         end
         held_v = plot && !plot_ready;
         hx = int'(plot_x);
         hy = int'(plot_y);
         hc = int'(plot_colour);
         if (done) begin
            check("done_queue_empty", exp_q.size(), 0);
            check("done_no_plot", int'(plot), 0);
            done_cnt++;
         end
      end
   end

   // Reference model: list every pixel of the rectangle in raster order.
   task automatic send(input int x0, input int y0, input int w, input int h, input int c,
                       output int acc_cyc, output int npix);
      int n;
      pix_t p;
      n = 0;
      npix = 0;
      @(posedge clock);
      #1;
      while (!req_ready && n < 5000) begin
         @(posedge clock);
         #1;
         n++;
      end
      check("req_ready_wait", int'(req_ready), 1);
      req_x0 = XW'(x0);
      req_y0 = YW'(y0);
      req_w = XW'(w);
      req_h = YW'(h);
      req_colour = CW'(c);
      req_valid = 1'b1;
      for (int yy = y0; yy <= y0 + h; yy++) begin
         for (int xx = x0; xx <= x0 + w; xx++) begin
`ifdef RECT_FILL_CLIP_EN
            if (xx < 160 && yy < 120) begin
               p.x = xx; p.y = yy; p.c = c;
               exp_q.push_back(p);
               npix++;
            end
`else
            p.x = xx % 256; p.y = yy % 128; p.c = c;
            exp_q.push_back(p);
            npix++;
`endif
         end
      end
      exp_plots += npix;
      exp_done++;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      acc_cyc = cyc;
      $display("request x0=%0d y0=%0d w=%0d h=%0d c=%0d accepted at cycle %0d (%0d plots)",
               x0, y0, w, h, c, acc_cyc, npix);
   endtask

   task automatic wait_done(input int limit, output int at_cyc);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!done && n < limit);
      check("done_seen", int'(done), 1);
      at_cyc = cyc;
   endtask

   initial begin
      int a, d, np, base, n;

      repeat (3) @(posedge clock);
      #1;
      resetn = 1'b1;
      @(negedge clock);
      check("reset_req_ready", int'(req_ready), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_plot", int'(plot), 0);
      check("reset_done", int'(done), 0);

      // Basic 3x2 fill at full throughput.
      rdy_mode = 0;
      send(10, 20, 2, 1, 5, a, np);
      wait_done(200, d);
      check("t1_latency", d - a, 6);
      @(negedge clock);
      check("t1_done_one_cycle", int'(done), 0);
      check("t1_ready_after", int'(req_ready), 1);

      // Single pixel.
      send(0, 0, 0, 0, 3, a, np);
      wait_done(200, d);
      check("t2_latency", d - a, 1);

      // Fixed backpressure pattern.
      rdy_mode = 2;
      send(10, 20, 2, 1, 5, a, np);
      wait_done(200, d);
      rdy_mode = 0;

      // Requests during a fill are ignored.
      send(10, 20, 2, 1, 6, a, np);
      for (int i = 0; i < 3; i++) begin
         req_x0 = 8'd50;
         req_valid = 1'b1;
         @(posedge clock);
         #1;
         check("t4_ready_low", int'(req_ready), 0);
      end
      req_valid = 1'b0;
      wait_done(200, d);

      // Reset in the middle of a fill.
      base = accepted;
      send(5, 6, 5, 3, 2, a, np);
      n = 0;
      while (accepted < base + 3 && n < 200) begin
         @(negedge clock);
         n++;
      end
      @(posedge clock);
      #1;
      resetn = 1'b0;
      #1;
      check("t5_plot_drop", int'(plot), 0);
      check("t5_done_low", int'(done), 0);
      check("t5_ready_high", int'(req_ready), 1);
      exp_plots -= exp_q.size();
      exp_q.delete();
      exp_done--;
      @(posedge clock);
      #1;
      resetn = 1'b1;
      @(negedge clock);
      check("t5_ready_after", int'(req_ready), 1);
      send(7, 9, 1, 1, 4, a, np);
      wait_done(200, d);
      check("t5_restart_latency", d - a, 4);

      // Rectangle straddling the screen edge.
      base = accepted;
      send(158, 118, 3, 3, 6, a, np);
      wait_done(200, d);
      check("t6_latency", d - a, 16);
`ifdef RECT_FILL_CLIP_EN
      check("t6_plots", accepted - base, 4);
`else
      check("t6_plots", accepted - base, 16);
`endif

      // Full-width extent with random backpressure.
      rdy_mode = 1;
      send(3, 100, 255, 1, 7, a, np);
      wait_done(4000, d);

      // Random rectangles.
      for (int i = 0; i < 20; i++) begin
         send(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 7)), a, np);
         wait_done(1000, d);
      end
      rdy_mode = 0;

      repeat (3) @(negedge clock);
      check("final_queue_empty", exp_q.size(), 0);
      check("final_done_count", done_cnt, exp_done);
      check("final_plot_count", accepted, exp_plots);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
